// File: rtl/alu_wb_buffer.sv
// ALU result buffer: small in-order FIFO between the ALU and the writeback
// arbiter. It holds the result, branch flag and transaction ID of each entry
// and presents the oldest entry over a valid/ready handshake. A flush clears it.
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       alu_valid_i,
  output logic                       alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0]   alu_trans_id_i,
  input  logic [XLEN-1:0]            alu_result_i,
  input  logic                       alu_branch_res_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output logic [XLEN-1:0]            wb_result_o,
  output logic                       wb_branch_res_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0][XLEN-1:0]          res_q;
  logic [DEPTH-1:0][TRANS_ID_BITS-1:0] id_q;
  logic [DEPTH-1:0]                    br_q;
  logic [PW-1:0]                       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                       count_q, count_d;
  logic                                push, pop;

  // Accept only from registered occupancy; wb_ready_i never reaches alu_ready_o.
  assign alu_ready_o = (count_q != CW'(DEPTH)) & ~flush_i;
  assign wb_valid_o  = (count_q != '0);
  assign push        = alu_valid_i & alu_ready_o;
  assign pop         = wb_valid_o & wb_ready_i;
  assign count_o     = count_q;

  // Head entry drives writeback; zeroed when the buffer is empty.
  always_comb begin
    wb_trans_id_o   = '0;
    wb_result_o     = '0;
    wb_branch_res_o = 1'b0;
    if (wb_valid_o) begin
      wb_trans_id_o   = id_q[rd_ptr_q];
      wb_result_o     = res_q[rd_ptr_q];
      wb_branch_res_o = br_q[rd_ptr_q];
    end
  end

  // Pointer/occupancy next state; a flush overrides any push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written at the tail on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_q <= '0;
      id_q  <= '0;
      br_q  <= '0;
    end else if (push) begin
      res_q[wr_ptr_q] <= alu_result_i;
      id_q[wr_ptr_q]  <= alu_trans_id_i;
      br_q[wr_ptr_q]  <= alu_branch_res_i;
    end
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed table-driven bench for alu_wb_buffer (DEPTH=2) plus hand-written
// reset sequences.
module tb_alu_wb_buffer;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, alu_valid_i, alu_ready_o, alu_branch_res_i;
  logic [2:0]  alu_trans_id_i, wb_trans_id_o;
  logic [63:0] alu_result_i, wb_result_o;
  logic        wb_valid_o, wb_ready_i, wb_branch_res_o;
  logic [1:0]  count_o;

  int errors = 0;
  int checks = 0;

  alu_wb_buffer #(.XLEN(64), .TRANS_ID_BITS(3), .DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_trans_id_i(alu_trans_id_i), .alu_result_i(alu_result_i),
    .alu_branch_res_i(alu_branch_res_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o),
    .wb_branch_res_o(wb_branch_res_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        fl, v;
    logic [2:0]  id;
    logic [63:0] res;
    logic        br, wbr;
    logic        e_rdy, e_wbv;
    logic [2:0]  e_id;
    logic [63:0] e_res;
    logic        e_br;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic fl, logic v, logic [2:0] id, logic [63:0] res,
                              logic br, logic wbr, logic e_rdy, logic e_wbv,
                              logic [2:0] e_id, logic [63:0] e_res, logic e_br,
                              logic [1:0] e_cnt);
    vec_t t;
    t.fl = fl; t.v = v; t.id = id; t.res = res; t.br = br; t.wbr = wbr;
    t.e_rdy = e_rdy; t.e_wbv = e_wbv; t.e_id = e_id; t.e_res = e_res;
    t.e_br = e_br; t.e_cnt = e_cnt;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_outs(string tag, logic e_rdy, logic e_wbv, logic [2:0] e_id,
                            logic [63:0] e_res, logic e_br, logic [1:0] e_cnt);
    chk({tag, " alu_ready"}, 64'(alu_ready_o), 64'(e_rdy));
    chk({tag, " wb_valid"}, 64'(wb_valid_o), 64'(e_wbv));
    chk({tag, " wb_id"}, 64'(wb_trans_id_o), 64'(e_id));
    chk({tag, " wb_result"}, wb_result_o, e_res);
    chk({tag, " wb_branch"}, 64'(wb_branch_res_o), 64'(e_br));
    chk({tag, " count"}, 64'(count_o), 64'(e_cnt));
  endtask

  // Drive one cycle of inputs at the falling edge, check outputs 1ns later.
  task automatic apply(string tag, vec_t t);
    @(negedge clk_i);
    flush_i = t.fl; alu_valid_i = t.v; alu_trans_id_i = t.id;
    alu_result_i = t.res; alu_branch_res_i = t.br; wb_ready_i = t.wbr;
    #1;
    check_outs(tag, t.e_rdy, t.e_wbv, t.e_id, t.e_res, t.e_br, t.e_cnt);
  endtask

  function automatic logic [63:0] rk(int k);
    return 64'hC0DE_0000_0000_0000 | 64'(k);
  endfunction

  initial begin
    vec_t t;
    logic [2:0] km1;
    // Single pass
    add(0,1,3,64'hDEAD_BEEF_0000_0001,1,1, 1,0,0,0,0,0);
    add(0,0,0,0,0,1, 1,1,3,64'hDEAD_BEEF_0000_0001,1,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);
    // Fill and stall; id 5 dropped while full
    add(0,1,1,64'hA1,0,0, 1,0,0,0,0,0);
    add(0,1,2,64'hA2,1,0, 1,1,1,64'hA1,0,1);
    add(0,1,5,64'hA5,1,0, 0,1,1,64'hA1,0,2);
    add(0,0,0,0,0,1, 0,1,1,64'hA1,0,2);
    add(0,0,0,0,0,1, 1,1,2,64'hA2,1,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);
    // Simultaneous push/pop, ids 0..7
    add(0,1,0,rk(0),0,1, 1,0,0,0,0,0);
    for (int k = 1; k < 8; k++) begin
      km1 = 3'(k - 1);
      add(0,1,3'(k),rk(k),k[0],1, 1,1,km1,rk(k-1),km1[0],1);
    end
    add(0,0,0,0,0,1, 1,1,7,rk(7),1,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);
    // Flush at count=2 with push of id 6 offered
    add(0,1,1,64'hB1,1,0, 1,0,0,0,0,0);
    add(0,1,2,64'hB2,0,0, 1,1,1,64'hB1,1,1);
    add(1,1,6,64'hB6,1,0, 0,1,1,64'hB1,1,2);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);
    // Flush together with a pop
    add(0,1,3,64'hB3,0,0, 1,0,0,0,0,0);
    add(1,0,0,0,0,1, 0,1,3,64'hB3,0,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);
    // Pointers restart cleanly after flush
    add(0,1,7,64'hB7,1,0, 1,0,0,0,0,0);
    add(0,0,0,0,0,1, 1,1,7,64'hB7,1,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0);

    // Reset held with random non-flush inputs
    rst_ni = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      alu_valid_i = 1'($urandom); alu_trans_id_i = 3'($urandom);
      alu_result_i = {$urandom, $urandom}; alu_branch_res_i = 1'($urandom);
      wb_ready_i = 1'($urandom);
      #1;
      check_outs("reset", 1, 0, 0, 0, 0, 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1; alu_valid_i = 1'b0; wb_ready_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);

    // Async reset mid-cycle with two entries buffered
    t = '{0,1,1,64'hE1,0,0, 1,0,0,0,0,0};   apply("ar_push1", t);
    t = '{0,1,2,64'hE2,1,0, 1,1,1,64'hE1,0,1}; apply("ar_push2", t);
    t = '{0,0,0,0,0,0, 0,1,1,64'hE1,0,2};   apply("ar_full", t);
    #1 rst_ni = 1'b0;
    #1 check_outs("ar_async", 1, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    t = '{0,1,4,64'h4444_0000_0000_0004,1,1, 1,0,0,0,0,0}; apply("ar_push4", t);
    t = '{0,0,0,0,0,1, 1,1,4,64'h4444_0000_0000_0004,1,1}; apply("ar_out4", t);
    t = '{0,0,0,0,0,0, 1,0,0,0,0,0};                       apply("ar_empty", t);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
